reorder_buffer: RTL and testbench

In-order retirement buffer directly downstream of register renaming. It accepts renamed instructions (arch dest, new phys dest, old phys dest) in program order, marks them complete from the CDB, and retires them in order. On each retirement it returns the superseded physical register to the free list via commit_flag/commit_phys_reg. One dispatch and one retirement per cycle maximum.

---
 rtl/rob_pkg.sv | 19 +
 rtl/reorder_buffer_if.sv | 39 +++
 rtl/rob_ptr.sv | 35 +++
 rtl/reorder_buffer.sv | 135 +++++++++++++
 tb/tb_reorder_buffer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared defaults and types for the reorder buffer slice.
package rob_pkg;
    localparam int ROB_DEPTH_DEFAULT   = 8;
    localparam int PHYS_ADDR_W_DEFAULT = 5;
    localparam int ARCH_ADDR_W_DEFAULT = 5;
    localparam int ROB_IDX_W           = $clog2(ROB_DEPTH_DEFAULT);

    typedef logic [ROB_IDX_W-1:0] ROB_IDX;
    // Index plus wrap bit in the MSB
    typedef logic [ROB_IDX_W:0]   ROB_PTR;

    typedef struct packed {
        logic                           valid;
        logic                           done;
        logic [ARCH_ADDR_W_DEFAULT-1:0] arch_dest;
        logic [PHYS_ADDR_W_DEFAULT-1:0] phys_dest;
        logic [PHYS_ADDR_W_DEFAULT-1:0] phys_dest_old;
    } ROB_ENTRY;
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion and retirement signals of the reorder buffer.
interface reorder_buffer_if
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH   = ROB_DEPTH_DEFAULT,
    parameter int PHYS_ADDR_W = PHYS_ADDR_W_DEFAULT,
    parameter int ARCH_ADDR_W = ARCH_ADDR_W_DEFAULT
);
    localparam int IDX_W = $clog2(ROB_DEPTH);

    logic                   dispatch_valid;
    logic [ARCH_ADDR_W-1:0] dispatch_arch_dest;
    logic [PHYS_ADDR_W-1:0] dispatch_phys_dest;
    logic [PHYS_ADDR_W-1:0] dispatch_phys_dest_old;
    logic                   dispatch_ready;
    logic [IDX_W-1:0]       dispatch_tag;
    logic                   cdb_valid;
    logic [IDX_W-1:0]       cdb_tag;
    logic                   retire_valid;
    logic [ARCH_ADDR_W-1:0] commit_arch_dest;
    logic [PHYS_ADDR_W-1:0] commit_phys_dest;
    logic                   commit_flag;
    logic [PHYS_ADDR_W-1:0] commit_phys_reg;
    logic [IDX_W:0]         count;

    modport master (
        output dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_dest_old,
        output cdb_valid, cdb_tag,
        input  dispatch_ready, dispatch_tag, retire_valid, commit_arch_dest,
        input  commit_phys_dest, commit_flag, commit_phys_reg, count
    );

    modport slave (
        input  dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_dest_old,
        input  cdb_valid, cdb_tag,
        output dispatch_ready, dispatch_tag, retire_valid, commit_arch_dest,
        output commit_phys_dest, commit_flag, commit_phys_reg, count
    );
endinterface

// File: rtl/rob_ptr.sv
// Circular pointer with wrap bit; clear_i returns it to zero like reset.
module rob_ptr
    import rob_pkg::*;
#(
    parameter int IDX_W = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             wrap_o
);
    logic [IDX_W:0] ptr_q;
    logic [IDX_W:0] ptr_d;

    // Depth is a power of two, so index overflow carries straight into the wrap bit
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + {{IDX_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign idx_o  = ptr_q[IDX_W-1:0];
    assign wrap_o = ptr_q[IDX_W];
endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer fed by rename; frees superseded physical registers on retire.
// Optional flush input enabled by defining ROB_FLUSH_EN.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH   = ROB_DEPTH_DEFAULT,
    parameter int PHYS_ADDR_W = PHYS_ADDR_W_DEFAULT,
    parameter int ARCH_ADDR_W = ARCH_ADDR_W_DEFAULT
) (
    input logic clk,
    input logic reset,
`ifdef ROB_FLUSH_EN
    input logic flush,
`endif
    reorder_buffer_if.slave rob
);
    localparam int IDX_W = $clog2(ROB_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             head_wrap;
    logic             tail_wrap;
    logic             flush_w;
    logic             dispatch_fire;
    logic             retire_fire;
    logic             cdb_hit;

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] valid_d;
    logic [ROB_DEPTH-1:0] done_q;
    logic [ROB_DEPTH-1:0] done_d;
    logic [ROB_DEPTH-1:0] wr_sel;
    logic [ROB_DEPTH-1:0] rt_sel;
    logic [ROB_DEPTH-1:0] cdb_sel;

    logic [ARCH_ADDR_W-1:0] arch_q [ROB_DEPTH];
    logic [PHYS_ADDR_W-1:0] phys_q [ROB_DEPTH];
    logic [PHYS_ADDR_W-1:0] old_q  [ROB_DEPTH];

    logic                   retire_valid_q;
    logic                   commit_flag_q;
    logic [ARCH_ADDR_W-1:0] commit_arch_q;
    logic [PHYS_ADDR_W-1:0] commit_phys_q;
    logic [PHYS_ADDR_W-1:0] commit_reg_q;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    rob_ptr #(.IDX_W(IDX_W)) u_head_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_w),
        .inc_i   (retire_fire),
        .idx_o   (head_idx),
        .wrap_o  (head_wrap)
    );

    rob_ptr #(.IDX_W(IDX_W)) u_tail_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush_w),
        .inc_i   (dispatch_fire),
        .idx_o   (tail_idx),
        .wrap_o  (tail_wrap)
    );

    // Pointer distance is the occupancy; the wrap bit separates full from empty
    assign rob.count          = {tail_wrap, tail_idx} - {head_wrap, head_idx};
    assign rob.dispatch_ready = (rob.count != CNT_W'(ROB_DEPTH));
    assign rob.dispatch_tag   = tail_idx;

    assign dispatch_fire = rob.dispatch_valid && rob.dispatch_ready;
    assign retire_fire   = valid_q[head_idx] && done_q[head_idx];
    assign cdb_hit       = rob.cdb_valid && valid_q[rob.cdb_tag]
                           && !(dispatch_fire && (rob.cdb_tag == tail_idx));

    // A slot is never written and retired in one cycle: that needs a full buffer, which blocks dispatch
    for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
        assign wr_sel[gi]  = dispatch_fire && (tail_idx == IDX_W'(gi));
        assign rt_sel[gi]  = retire_fire && (head_idx == IDX_W'(gi));
        assign cdb_sel[gi] = cdb_hit && (rob.cdb_tag == IDX_W'(gi));
        assign valid_d[gi] = wr_sel[gi] | (valid_q[gi] & ~rt_sel[gi]);
        assign done_d[gi]  = ~wr_sel[gi] & ~rt_sel[gi] & (done_q[gi] | cdb_sel[gi]);
    end

    always_ff @(posedge clk) begin
        if (reset || flush_w) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch_fire && !flush_w) begin
            arch_q[tail_idx] <= rob.dispatch_arch_dest;
            phys_q[tail_idx] <= rob.dispatch_phys_dest;
            old_q[tail_idx]  <= rob.dispatch_phys_dest_old;
        end
    end

    // Physical register 0 is the reset mapping and never goes back to the free list
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid_q <= 1'b0;
            commit_flag_q  <= 1'b0;
            commit_arch_q  <= '0;
            commit_phys_q  <= '0;
            commit_reg_q   <= '0;
        end else if (flush_w) begin
            retire_valid_q <= 1'b0;
            commit_flag_q  <= 1'b0;
        end else begin
            retire_valid_q <= retire_fire;
            commit_flag_q  <= retire_fire && (old_q[head_idx] != '0);
            if (retire_fire) begin
                commit_arch_q <= arch_q[head_idx];
                commit_phys_q <= phys_q[head_idx];
                commit_reg_q  <= old_q[head_idx];
            end
        end
    end

    assign rob.retire_valid     = retire_valid_q;
    assign rob.commit_flag      = commit_flag_q;
    assign rob.commit_arch_dest = commit_arch_q;
    assign rob.commit_phys_dest = commit_phys_q;
    assign rob.commit_phys_reg  = commit_reg_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and random stimulus against a queue-based program-order model of the ROB.
module tb_reorder_buffer;
    import rob_pkg::*;

    localparam int D     = ROB_DEPTH_DEFAULT;
    localparam int IDX_W = $clog2(D);
    localparam int AW    = ARCH_ADDR_W_DEFAULT;
    localparam int PW    = PHYS_ADDR_W_DEFAULT;

    logic clk = 1'b0;
    logic reset;
    logic flush_drv;

    always #5 clk = ~clk;

    reorder_buffer_if rif ();

    reorder_buffer dut (
        .clk   (clk),
        .reset (reset),
`ifdef ROB_FLUSH_EN
        .flush (flush_drv),
`endif
        .rob   (rif.slave)
    );

    typedef struct {
        int tag;
        int arch;
        int phys;
        int old;
        bit done;
    } ent_t;

    ent_t q[$];
    int   tail_m;
    bit   exp_rv;
    bit   exp_cf;
    int   exp_arch;
    int   exp_phys;
    int   exp_reg;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic check_regs();
        check("retire_valid", 32'(rif.retire_valid), 32'(exp_rv));
        check("commit_flag", 32'(rif.commit_flag), 32'(exp_cf));
        check("commit_arch_dest", 32'(rif.commit_arch_dest), exp_arch);
        check("commit_phys_dest", 32'(rif.commit_phys_dest), exp_phys);
        check("commit_phys_reg", 32'(rif.commit_phys_reg), exp_reg);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_drv = 1'b0;
        rif.dispatch_valid = 1'b0;
        rif.dispatch_arch_dest = '0;
        rif.dispatch_phys_dest = '0;
        rif.dispatch_phys_dest_old = '0;
        rif.cdb_valid = 1'b0;
        rif.cdb_tag = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        tail_m = 0;
        exp_rv = 1'b0;
        exp_cf = 1'b0;
        exp_arch = 0;
        exp_phys = 0;
        exp_reg = 0;
        check_regs();
        $display("txn %0d reset", txn);
    endtask

    // One clock cycle: drive at the falling edge, predict, then check after the rising edge
    task automatic step(input bit dv, input int a, input int p, input int o,
                        input bit cv, input int ct, input bit fl);
        bit fl_eff;
        bit ret;
        bit disp;
        txn++;
        rif.dispatch_valid = dv;
        rif.dispatch_arch_dest = AW'(a);
        rif.dispatch_phys_dest = PW'(p);
        rif.dispatch_phys_dest_old = PW'(o);
        rif.cdb_valid = cv;
        rif.cdb_tag = IDX_W'(ct);
        flush_drv = fl;
`ifdef ROB_FLUSH_EN
        fl_eff = fl;
`else
        fl_eff = 1'b0;
`endif
        check("count", 32'(rif.count), q.size());
        check("dispatch_ready", 32'(rif.dispatch_ready), 32'(q.size() != D));
        check("dispatch_tag", 32'(rif.dispatch_tag), tail_m);

        ret  = (q.size() > 0) && q[0].done;
        disp = dv && (q.size() != D);
        if (fl_eff) begin
            q.delete();
            tail_m = 0;
            exp_rv = 1'b0;
            exp_cf = 1'b0;
        end else begin
            if (cv) begin
                foreach (q[k]) if (q[k].tag == ct) q[k].done = 1'b1;
            end
            exp_rv = ret;
            exp_cf = 1'b0;
            if (ret) begin
                ent_t e;
                e = q.pop_front();
                exp_arch = e.arch;
                exp_phys = e.phys;
                exp_reg  = e.old;
                exp_cf   = (e.old != 0);
            end
            if (disp) begin
                q.push_back('{tag: tail_m, arch: a, phys: p, old: o, done: 1'b0});
                tail_m = (tail_m + 1) % D;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_regs();
        $display("txn %0d dv=%0d disp=%0d cdb=%0d/%0d flush=%0d retire=%0d free=%0d reg=%0d occ=%0d",
                 txn, dv, disp, cv, ct, fl_eff, exp_rv, exp_cf, exp_reg, q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic disp_one(input int a, input int p, input int o);
        step(1'b1, a, p, o, 1'b0, 0, 1'b0);
    endtask

    task automatic cdb_one(input int t);
        step(1'b0, 0, 0, 0, 1'b1, t, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        flush_drv = 1'b0;
        do_reset();

        // Three in-order completions with reset mappings as old regs
        disp_one(1, 5, 0);
        disp_one(2, 6, 0);
        disp_one(3, 7, 0);
        cdb_one(0);
        cdb_one(1);
        cdb_one(2);
        idle(3);

        // Freed register returned two cycles after completion
        do_reset();
        disp_one(4, 9, 4);
        cdb_one(0);
        idle(2);

        // Out-of-order completion still retires in program order
        do_reset();
        disp_one(7, 10, 11);
        disp_one(8, 12, 13);
        cdb_one(1);
        idle(2);
        cdb_one(0);
        idle(3);

        // Full buffer: extra dispatch ignored, retire does not free a slot that same cycle
        do_reset();
        for (int i = 0; i < D; i++) disp_one(i + 1, i + 8, i + 16);
        step(1'b1, 20, 21, 22, 1'b1, 0, 1'b0);
        step(1'b1, 20, 21, 22, 1'b0, 0, 1'b0);
        step(1'b1, 20, 21, 22, 1'b0, 0, 1'b0);
        for (int i = 1; i <= D; i++) cdb_one(i % D);
        idle(3);

        // Completion to an empty slot leaves no trace
        do_reset();
        cdb_one(5);
        for (int i = 0; i < 6; i++) disp_one(i + 2, i + 3, i + 1);
        for (int i = 0; i < 5; i++) cdb_one(i);
        idle(4);
        cdb_one(5);
        idle(2);

`ifdef ROB_FLUSH_EN
        do_reset();
        for (int i = 0; i < 4; i++) disp_one(i + 1, i + 5, i + 9);
        cdb_one(1);
        cdb_one(2);
        step(1'b1, 30, 31, 1, 1'b1, 3, 1'b1);
        idle(2);
`endif

        // Random traffic with occasional reset and flush
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 60,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                     $urandom_range(0, 99) < 70, int'($urandom_range(0, D - 1)),
                     $urandom_range(0, 99) < 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
